fetch_sequencer: RTL

//  Multi-cycle instruction sequencer that owns the program counter for the core.

---
 rtl/fetch_sequencer_if.sv | 47 ++++
 rtl/fetch_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Groups the instruction-memory fetch handshake and the datapath execute
//   handshake of the fetch sequencer into one bundle.
//
//   Handshake rules (both channels):
//     imem_req / imem_ack : the sequencer raises imem_req with imem_addr and
//       holds both stable until it sees imem_ack=1 at a rising clock edge. That
//       edge completes the fetch, and instr_rdata is captured in the same
//       cycle. An ack seen while no request is pending is ignored.
//     ex_valid / ex_done  : the sequencer raises ex_valid with instr_q/pc and
//       holds them until it sees ex_done=1 at a rising edge. That edge retires
//       the instruction, and is_branch/br_taken/is_jal/is_jalr/rs1_data are
//       sampled on it. A done seen while ex_valid=0 is ignored.
//
//   Parameters: PC_W - program counter width (word index)
//   Modports  : master - sequencer side; slave - imem + datapath side
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     instr_rdata;
  logic            ex_valid;
  logic            ex_done;
  logic            is_branch;
  logic            br_taken;
  logic            is_jal;
  logic            is_jalr;
  logic [31:0]     rs1_data;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] pc;

  modport master (
    output imem_req, imem_addr, ex_valid, instr_q, pc,
    input  imem_ack, instr_rdata, ex_done, is_branch, br_taken, is_jal,
           is_jalr, rs1_data
  );

  modport slave (
    input  imem_req, imem_addr, ex_valid, instr_q, pc,
    output imem_ack, instr_rdata, ex_done, is_branch, br_taken, is_jal,
           is_jalr, rs1_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Multi-cycle instruction sequencer that owns the program counter. It fetches
//   an instruction word from imem, holds it for the datapath until the datapath
//   reports completion, then moves the PC on to pc+1 or to a branch, JAL or
//   JALR target. The halt instruction parks the sequencer until reset.
//
//   Optional build macro: FETCH_STALL_CNT_EN
//     defined   - stall_count counts FETCH cycles that wait on imem_ack
//     undefined - stall_count is constant 0
//
//   Ports
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     run            start fetching when in IDLE (ignored in other states)
//     bus            fetch_sequencer_if.master: imem req/ack, ex valid/done,
//                    instr_q, pc
//     halted         high while parked in HALT
//     cycle_count    saturating count of FETCH/DECODE/EXEC cycles
//     retired_count  saturating count of retired instructions
//     stall_count    saturating count of imem wait cycles (see macro above)
//     state_dbg      current FSM state for debug and checkers
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int               PC_W      = 8,
  parameter int               CNT_W     = 11,
  parameter logic [PC_W-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      HALT_INSN = 32'h7F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  fetch_sequencer_if.master bus,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]  retired_count_q, retired_count_d;

  // ---------------------------------------------------------------------------
  // Next-PC targets. Immediates are byte offsets; the PC is a word index, so
  // branch/JAL offsets are arithmetically shifted right by 2. JALR adds its
  // immediate unshifted. All sums are 32-bit and then truncated to PC_W, which
  // gives wrap-around modulo 2^PC_W.
  // ---------------------------------------------------------------------------
  logic signed [31:0] br_imm, jal_imm, jalr_imm;
  logic signed [31:0] br_off, jal_off;
  logic        [31:0] pc_ext;
  logic        [31:0] target_sum;
  logic [PC_W-1:0]    next_pc;
  logic               unused_sum_bits;

  always_comb begin
    br_imm   = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                instr_q[11:8], 1'b0};
    jal_imm  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                instr_q[30:21], 1'b0};
    jalr_imm = {{20{instr_q[31]}}, instr_q[31:20]};
    br_off   = br_imm >>> 2;
    jal_off  = jal_imm >>> 2;
    pc_ext   = {{(32-PC_W){1'b0}}, pc_q};

    // A not-taken branch falls through to the JAL/JALR/sequential choices.
    if (bus.is_branch && bus.br_taken) begin
      target_sum = pc_ext + br_off;
    end else if (bus.is_jal) begin
      target_sum = pc_ext + jal_off;
    end else if (bus.is_jalr) begin
      target_sum = bus.rs1_data + jalr_imm;
    end else begin
      target_sum = pc_ext + 32'd1;
    end
    next_pc = target_sum[PC_W-1:0];
  end

  assign unused_sum_bits = ^target_sum[31:PC_W];

  // ---------------------------------------------------------------------------
  // FSM next state and datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    retired_count_d = retired_count_q;
    cycle_count_d   = cycle_count_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.instr_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (instr_q == HALT_INSN) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (bus.ex_done) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
          if (retired_count_q != '1) retired_count_d = retired_count_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q == S_FETCH || state_q == S_DECODE || state_q == S_EXEC) &&
        cycle_count_q != '1) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      instr_q         <= '0;
      cycle_count_q   <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      cycle_count_q   <= cycle_count_d;
      retired_count_q <= retired_count_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (state_q == S_FETCH && !bus.imem_ack && stall_count_q != '1) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

  // Handshake outputs decode straight from the state register so that reset
  // drops them immediately.
  assign bus.imem_req   = (state_q == S_FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.ex_valid   = (state_q == S_EXEC);
  assign bus.instr_q    = instr_q;
  assign bus.pc         = pc_q;
  assign halted         = (state_q == S_HALT);
  assign cycle_count    = cycle_count_q;
  assign retired_count  = retired_count_q;
  assign state_dbg      = state_q;

endmodule
